div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Multi-cycle sequential divider and its controlling FSM for the EX stage. Serves DIV/DIVU.
- EX raises a start request with two operands and holds it.
- The block iterates one quotient bit per clock, then returns {remainder, quotient} for HI/LO write-back. busy_o feeds the pipeline stall controller.
- Supports annulment, so a squashed instruction in EX can abort the division.

Parameters:
DATA_W, 32, operand width; iteration count equals DATA_W
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  reset, asynchronous and active-low (asserted when 0)
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
opdata1_i  input  DATA_W  dividend; sampled at accepting edge
opdata2_i  input  DATA_W  divisor; sampled at accepting edge
start_i  input  1  request; EX holds it high until it sees ready_o
annul_i  input  1  abort current or pending division
result_o  output  2*DATA_W  {remainder, quotient} = {HI, LO}
ready_o  output  1  result_o valid
busy_o  output  1  high in DivByZero and DivOn (stall request)

Behaviour:
- Reset (rst=0, async):
  - state=DivFree, cnt=0, working reg W=0.
  - result_o=0, ready_o=0, busy_o=0.
  - Reset mid-operation discards all progress.
- States: DivFree, DivByZero, DivOn, DivEnd. All outputs are registered or decoded from state only; there are no combinational input-to-output paths.
- DivFree:
  - Edge with start_i=1, annul_i=0, opdata2_i=0: go to DivByZero.
  - Edge with start_i=1, annul_i=0, opdata2_i!=0:
    - Latch signed_div_i, sign(opdata1_i), sign(opdata2_i).
    - |A| = two's-complement negation of opdata1_i if signed and MSB=1, otherwise opdata1_i. |B| is formed the same way from opdata2_i.
    - W(2*DATA_W+1 bits) <= {0, |A|}, cnt <= 0, go to DivOn.
  - ready_o=0, result_o=0.
- DivByZero: next edge sets W=0 and goes to DivEnd (result 0). annul_i or start_i=0 here goes to DivFree.
- DivOn, one iteration per edge:
  - S = W<<1.
  - If S[2*DATA_W:DATA_W] (DATA_W+1-bit compare) >= {0,|B|}, subtract |B| from that field and set S[0]=1.
  - W <= S, cnt <= cnt+1.
  - On the edge where cnt==DATA_W-1, go to DivEnd.
  - annul_i=1 or start_i=0 at any DivOn edge: go to DivFree, no result, no ready.
- DivEnd, each edge:
  - If start_i=1 and annul_i=0:
    - ready_o<=1.
    - result_o<={R,Q}, where Q=W[DATA_W-1:0] and R=W[2*DATA_W-1:DATA_W].
    - If signed, Q is negated when the operand signs differ, and R is negated when the dividend was negative.
  - Otherwise go to DivFree with ready_o<=0 and result_o<=0.
- Timing (E0 = accepting edge):
  - Nonzero divisor: 32 iterations at E1..E32, enter DivEnd at E32, ready_o/result_o high after E33. Latency is 33 clocks.
  - Zero divisor: ready_o high after E2.
- Holding: ready_o and result_o stay stable for as long as start_i stays high. The first edge with start_i=0 clears them. A new start is accepted only from DivFree, so there is at least one idle cycle between operations.
- Signed special case: 0x80000000 / 0xFFFFFFFF gives Q=0x80000000, R=0 with no trap. |A|=0x80000000 is treated as unsigned magnitude.
- Simultaneous start_i and annul_i in DivFree: annul wins and the request is not accepted.

Test Plan:
- Unsigned: DIVU 100/7, start held. Expect:
  - busy_o=1 from E0+.
  - ready_o first high after E33.
  - result_o={32'd2, 32'd14}.
  - Drop start: ready_o=0 and result_o=0 after the next edge.
- Signed: DIV -7/2. Expect result_o={0xFFFFFFFF, 0xFFFFFFFD}. Also DIV 7/-2 → {0x00000001, 0xFFFFFFFD}. Also 0x80000000/0xFFFFFFFF → {0, 0x80000000}.
- Divide by zero: opdata2_i=0 at E0. Expect:
  - DivByZero after E0, DivEnd after E1.
  - ready_o=1 and result_o=0 after E2.
  - busy_o=1 for exactly one cycle.
- Annul: assert annul_i at the edge with cnt=10. Expect:
  - DivFree next cycle, ready_o never rises.
  - A fresh DIVU 9/3 started afterward returns {0, 3} after 33 clocks.
- Async reset: pull rst low mid-DivOn, between clock edges. Expect state=DivFree, ready_o=0, busy_o=0, result_o=0 immediately, without waiting for a clock edge.
- Hold/back-to-back: keep start high 5 cycles after ready. Expect:
  - result_o stable throughout.
  - Drop start for 1 cycle, then re-raise with new operands: accepted from DivFree, correct new result after 33 clocks.

Source files
------------

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl
// Description : Multi-cycle restoring divider with its control FSM for the
//               EX stage (DIV / DIVU). Produces one quotient bit per clock
//               and returns {remainder, quotient} for HI/LO write-back.
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   asynchronous reset, active low
//   signed_div_i  in   1 = DIV (signed), 0 = DIVU
//   opdata1_i     in   dividend  [DATA_W-1:0]
//   opdata2_i     in   divisor   [DATA_W-1:0]
//   start_i       in   request, held by EX until ready_o is seen
//   annul_i       in   abort current or pending division
//   result_o      out  {remainder, quotient} [2*DATA_W-1:0]
//   ready_o       out  result_o valid
//   busy_o        out  stall request (DivByZero / DivOn)
//
// Revision    : 1.0  initial release
// ============================================================================
module div_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        DIV_FREE = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_ON   = 2'd2,
        DIV_END  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(DATA_W - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [CNT_W-1:0]       r_cnt;
    logic [2*DATA_W:0]      r_w;        // {partial remainder, dividend/quotient}
    logic [DATA_W-1:0]      r_abs_b;
    logic                   r_neg_a;    // signed op with negative dividend
    logic                   r_neg_b;    // signed op with negative divisor
    logic [2*DATA_W-1:0]    r_result;
    logic                   r_ready;

    logic                   w_go;       // request present and not annulled
    logic [DATA_W-1:0]      w_abs_a;
    logic [DATA_W-1:0]      w_abs_b;
    logic [2*DATA_W:0]      w_shift;
    logic [DATA_W:0]        w_hi;
    logic [DATA_W:0]        w_diff;
    logic                   w_ge;
    logic [2*DATA_W:0]      w_step;
    logic [DATA_W-1:0]      w_q;
    logic [DATA_W-1:0]      w_r;
    logic [DATA_W-1:0]      w_q_fix;
    logic [DATA_W-1:0]      w_r_fix;

    assign w_go = start_i & ~annul_i;

    // Magnitudes; the most negative value maps onto itself and is then
    // interpreted as an unsigned magnitude, so no overflow trap is needed.
    assign w_abs_a = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign w_abs_b = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    // One restoring step: shift left, trial-subtract the divisor from the
    // upper DATA_W+1 bits, and shift in a 1 when the subtraction fits.
    assign w_shift = {r_w[2*DATA_W-1:0], 1'b0};
    assign w_hi    = w_shift[2*DATA_W:DATA_W];
    assign w_ge    = (w_hi >= {1'b0, r_abs_b});
    assign w_diff  = w_hi - {1'b0, r_abs_b};
    assign w_step  = w_ge ? {w_diff, w_shift[DATA_W-1:1], 1'b1} : w_shift;

    // Sign fix-up: quotient negative when signs differ, remainder follows
    // the sign of the dividend.
    assign w_q     = r_w[DATA_W-1:0];
    assign w_r     = r_w[2*DATA_W-1:DATA_W];
    assign w_q_fix = (r_neg_a ^ r_neg_b) ? -w_q : w_q;
    assign w_r_fix = r_neg_a ? -w_r : w_r;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DIV_FREE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            DIV_FREE: begin
                if (w_go) begin
                    w_state_nxt = (opdata2_i == '0) ? DIV_ZERO : DIV_ON;
                end
            end
            DIV_ZERO: begin
                w_state_nxt = w_go ? DIV_END : DIV_FREE;
            end
            DIV_ON: begin
                if (!w_go) begin
                    w_state_nxt = DIV_FREE;
                end else if (r_cnt == C_LAST_ITER) begin
                    w_state_nxt = DIV_END;
                end
            end
            DIV_END: begin
                if (!w_go) begin
                    w_state_nxt = DIV_FREE;
                end
            end
            default: w_state_nxt = DIV_FREE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_w      <= '0;
            r_abs_b  <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            unique case (r_state)
                DIV_FREE: begin
                    r_ready  <= 1'b0;
                    r_result <= '0;
                    if (w_go && (opdata2_i != '0)) begin
                        r_w     <= {{(DATA_W+1){1'b0}}, w_abs_a};
                        r_cnt   <= '0;
                        r_abs_b <= w_abs_b;
                        r_neg_a <= signed_div_i & opdata1_i[DATA_W-1];
                        r_neg_b <= signed_div_i & opdata2_i[DATA_W-1];
                    end
                end
                DIV_ZERO: begin
                    // Clearing W here makes the DivEnd result all zeros.
                    r_w <= '0;
                end
                DIV_ON: begin
                    if (w_go) begin
                        r_w   <= w_step;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DIV_END: begin
                    if (w_go) begin
                        r_ready  <= 1'b1;
                        r_result <= {w_r_fix, w_q_fix};
                    end else begin
                        r_ready  <= 1'b0;
                        r_result <= '0;
                    end
                end
                default: begin
                    r_ready  <= 1'b0;
                    r_result <= '0;
                end
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign busy_o   = (r_state == DIV_ZERO) || (r_state == DIV_ON);

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_ctrl
// Description : Self-checking bench for div_ctrl: table of directed vectors,
//               hand-written corner sequences (annul, async reset, hold,
//               simultaneous start/annul) and random operations checked
//               against an arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int tests;
    int fails;

    div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero. Wide
    // arithmetic makes 0x80000000 / -1 come out as +2^31, which wraps back
    // to 0x80000000 in 32 bits.
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint q;
        longint r;
        longint sa;
        longint sb;
        logic [63:0] qv;
        logic [63:0] rv;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one operation, check busy, latency and result, hold start for
    // 'hold' extra cycles, then drop start and check the outputs clear.
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int hold, input string nm);
        int cyc;
        int busy_cnt;
        int lat_exp;
        logic [63:0] held;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        lat_exp      = (b == 32'd0) ? 2 : 33;
        tick();                                   // E0
        check({nm, " busy_after_E0"}, {63'd0, busy_o}, 64'd1);
        busy_cnt = busy_o ? 1 : 0;
        cyc = 0;
        while (1) begin
            tick();
            cyc++;
            if (ready_o) break;
            if (busy_o) busy_cnt++;
            if (cyc >= 80) break;
        end
        check({nm, " latency"}, 64'(cyc), 64'(lat_exp));
        check({nm, " busy_cycles"}, 64'(busy_cnt), (b == 32'd0) ? 64'd1 : 64'd32);
        check({nm, " result"}, result_o, exp);
        held = result_o;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({nm, " hold"}, {ready_o, result_o == held}, {1'b1, 1'b1});
        end
        start_i = 1'b0;
        tick();
        check({nm, " clear_ready"}, {63'd0, ready_o}, 64'd0);
        check({nm, " clear_result"}, result_o, 64'd0);
    endtask

    initial begin
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        bit          saw_ready;

        tests = 0;
        fails = 0;
        rst          = 1'b0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,        {32'd2,        32'd14}};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}};
        vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h00000000, 32'h80000000}};
        vecs[4]  = '{1'b0, 32'd9,          32'd3,        {32'd0,        32'd3}};
        vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,        {32'd0,        32'hFFFFFFFF}};
        vecs[6]  = '{1'b0, 32'd5,          32'd0,        {32'd0,        32'd0}};
        vecs[7]  = '{1'b0, 32'd3,          32'd10,       {32'd3,        32'd0}};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E}};
        vecs[9]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF, {32'h80000000, 32'h00000000}};
        vecs[10] = '{1'b1, 32'hFFFFFFF9,   32'd0,        {32'd0,        32'd0}};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {result_o, ready_o, busy_o}, '0);
        rst = 1'b1;
        tick();
        check("idle_after_reset", {result_o, ready_o, busy_o}, '0);

        // Directed table; the first entry holds start for 5 cycles.
        for (int i = 0; i < 11; i++) begin
            run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp,
                    (i == 0) ? 5 : 1, $sformatf("vec%0d", i));
        end

        // Annul on the edge where 10 iterations have completed.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        tick();                                   // E0
        repeat (10) tick();                       // E1..E10
        annul_i = 1'b1;
        tick();                                   // E11 with annul
        check("annul_to_free", {62'd0, busy_o, ready_o}, 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        saw_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready_o) saw_ready = 1'b1;
        end
        check("annul_no_ready", {63'd0, saw_ready}, 64'd0);
        run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0, "after_annul");

        // Simultaneous start and annul in DivFree is not accepted.
        opdata1_i = 32'd20;
        opdata2_i = 32'd4;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        tick();
        tick();
        check("start_annul_ignored", {62'd0, busy_o, ready_o}, 64'd0);
        annul_i = 1'b0;
        tick();
        check("accept_after_annul_drop", {63'd0, busy_o}, 64'd1);
        // Dropping start mid-operation aborts it.
        repeat (3) tick();
        start_i = 1'b0;
        tick();
        check("start_drop_abort", {62'd0, busy_o, ready_o}, 64'd0);
        tick();

        // Asynchronous reset in the middle of DivOn.
        opdata1_i = 32'd12345;
        opdata2_i = 32'd17;
        start_i   = 1'b1;
        tick();
        repeat (5) @(posedge clk);
        #2;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        check("async_rst_divon", {result_o, ready_o, busy_o}, '0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Asynchronous reset while a result is being held.
        opdata1_i = 32'd50;
        opdata2_i = 32'd6;
        start_i   = 1'b1;
        repeat (35) tick();
        check("pre_rst_result", result_o, {32'd2, 32'd8});
        @(posedge clk);
        #2;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        check("async_rst_divend", {result_o, ready_o, busy_o}, '0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Random operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 4))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 16));
                2:       b = 32'd0;
                3:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 7));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            run_div(sgn, a, b, model(sgn, a, b), $urandom_range(0, 2),
                    $sformatf("rand%0d s=%0d a=%h b=%h", i, sgn, a, b));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
